// File: rtl/tlb_arb_pkg.sv
// Shared types and constants for the TLB search-port arbiter.
package tlb_arb_pkg;

    localparam int unsigned VPN2_W = 19;
    localparam int unsigned PFN_W  = 20;
    localparam int unsigned ASID_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OWN_INST = 2'd0,
        OWN_DATA = 2'd1,
        OWN_TLBP = 2'd2
    } owner_e;

    // Bit positions of the one-hot winner vector.
    localparam int unsigned PICK_INST = 0;
    localparam int unsigned PICK_DATA = 1;
    localparam int unsigned PICK_TLBP = 2;

    function automatic owner_e pick_to_owner(input logic [2:0] pick);
        if (pick[PICK_TLBP]) return OWN_TLBP;
        if (pick[PICK_DATA]) return OWN_DATA;
        return OWN_INST;
    endfunction

endpackage

// File: rtl/tlb_search_arbiter_if.sv
// Requester handshakes plus the TLB search port of the arbiter.
interface tlb_search_arbiter_if #(
    parameter int unsigned TLBNUM = 16
);
    import tlb_arb_pkg::*;

    localparam int unsigned IDX_W = $clog2(TLBNUM);

    logic              inst_req, inst_odd, inst_gnt, inst_rvalid;
    logic [VPN2_W-1:0] inst_vpn2;
    logic              data_req, data_odd, data_gnt, data_rvalid;
    logic [VPN2_W-1:0] data_vpn2;
    logic              tlbp_req, tlbp_gnt, tlbp_rvalid;
    logic [31:0]       cp0_entryhi;
    logic              tlb_write;

    logic [VPN2_W-1:0] s_vpn2;
    logic              s_odd_page;
    logic [ASID_W-1:0] s_asid;
    logic              s_found, s_d, s_v;
    logic [IDX_W-1:0]  s_index;
    logic [PFN_W-1:0]  s_pfn;
    logic [2:0]        s_c;

    logic              r_found, r_d, r_v;
    logic [IDX_W-1:0]  r_index;
    logic [PFN_W-1:0]  r_pfn;
    logic [2:0]        r_c;
    logic              busy;

    modport master (
        output inst_req, inst_vpn2, inst_odd, data_req, data_vpn2, data_odd,
               tlbp_req, cp0_entryhi, tlb_write,
               s_found, s_index, s_pfn, s_c, s_d, s_v,
        input  inst_gnt, inst_rvalid, data_gnt, data_rvalid, tlbp_gnt, tlbp_rvalid,
               s_vpn2, s_odd_page, s_asid,
               r_found, r_index, r_pfn, r_c, r_d, r_v, busy
    );

    modport slave (
        input  inst_req, inst_vpn2, inst_odd, data_req, data_vpn2, data_odd,
               tlbp_req, cp0_entryhi, tlb_write,
               s_found, s_index, s_pfn, s_c, s_d, s_v,
        output inst_gnt, inst_rvalid, data_gnt, data_rvalid, tlbp_gnt, tlbp_rvalid,
               s_vpn2, s_odd_page, s_asid,
               r_found, r_index, r_pfn, r_c, r_d, r_v, busy
    );

endinterface

// File: rtl/tlb_req_pick.sv
// Fixed-priority TLBP over round-robin inst/data selection; purely combinational.
module tlb_req_pick
    import tlb_arb_pkg::*;
(
    input  logic       inst_req,
    input  logic       data_req,
    input  logic       tlbp_req,
    input  logic       last_served, // 0: inst served last, 1: data served last
    output logic [2:0] winner,
    output logic       valid
);

    always_comb begin
        winner = '0;
        if (tlbp_req) begin
            winner[PICK_TLBP] = 1'b1;
        end else if (inst_req && data_req) begin
            if (last_served) winner[PICK_INST] = 1'b1;
            else             winner[PICK_DATA] = 1'b1;
        end else if (inst_req) begin
            winner[PICK_INST] = 1'b1;
        end else if (data_req) begin
            winner[PICK_DATA] = 1'b1;
        end
        valid = |winner;
    end

endmodule

// File: rtl/tlb_search_arbiter.sv
// Shares the single TLB search port among inst/data micro-TLB refills and TLBP.
module tlb_search_arbiter
    import tlb_arb_pkg::*;
#(
    parameter int unsigned TLBNUM = 16
) (
    input logic                 clk,
    input logic                 reset,
    tlb_search_arbiter_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(TLBNUM);

    state_e            state_q, state_d;
    owner_e            owner_q;
    logic              last_served_q;
    logic [VPN2_W-1:0] key_vpn2_q;
    logic              key_odd_q;
    logic [ASID_W-1:0] key_asid_q;

    logic              r_found_q, r_d_q, r_v_q;
    logic [IDX_W-1:0]  r_index_q;
    logic [PFN_W-1:0]  r_pfn_q;
    logic [2:0]        r_c_q;

    logic [2:0]        pick;
    logic              pick_valid;
    logic              grant_en;
    logic              unused_entryhi;

    assign unused_entryhi = ^bus.cp0_entryhi[12:8];

    tlb_req_pick u_pick (
        .inst_req    (bus.inst_req),
        .data_req    (bus.data_req),
        .tlbp_req    (bus.tlbp_req),
        .last_served (last_served_q),
        .winner      (pick),
        .valid       (pick_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (grant_en) state_d = LOOKUP;
            // A TLB write during the search reruns it so the result is never stale.
            LOOKUP:  if (!bus.tlb_write) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant_en        = (state_q == IDLE) && !reset && !bus.tlb_write && pick_valid;
        bus.inst_gnt    = grant_en && pick[PICK_INST];
        bus.data_gnt    = grant_en && pick[PICK_DATA];
        bus.tlbp_gnt    = grant_en && pick[PICK_TLBP];
        bus.inst_rvalid = (state_q == RESP) && (owner_q == OWN_INST);
        bus.data_rvalid = (state_q == RESP) && (owner_q == OWN_DATA);
        bus.tlbp_rvalid = (state_q == RESP) && (owner_q == OWN_TLBP);
        bus.busy        = (state_q != IDLE);
        bus.s_vpn2      = key_vpn2_q;
        bus.s_odd_page  = key_odd_q;
        bus.s_asid      = key_asid_q;
        bus.r_found     = r_found_q;
        bus.r_index     = r_index_q;
        bus.r_pfn       = r_pfn_q;
        bus.r_c         = r_c_q;
        bus.r_d         = r_d_q;
        bus.r_v         = r_v_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q       <= OWN_INST;
            last_served_q <= 1'b0;
            key_vpn2_q    <= '0;
            key_odd_q     <= 1'b0;
            key_asid_q    <= '0;
        end else if (grant_en) begin
            owner_q    <= pick_to_owner(pick);
            key_asid_q <= bus.cp0_entryhi[ASID_W-1:0];
            if (pick[PICK_TLBP]) begin
                key_vpn2_q <= bus.cp0_entryhi[31:13];
                key_odd_q  <= 1'b0;
            end else if (pick[PICK_DATA]) begin
                key_vpn2_q <= bus.data_vpn2;
                key_odd_q  <= bus.data_odd;
            end else begin
                key_vpn2_q <= bus.inst_vpn2;
                key_odd_q  <= bus.inst_odd;
            end
            if (!pick[PICK_TLBP]) last_served_q <= pick[PICK_DATA];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_found_q <= 1'b0;
            r_index_q <= '0;
            r_pfn_q   <= '0;
            r_c_q     <= '0;
            r_d_q     <= 1'b0;
            r_v_q     <= 1'b0;
        end else if (state_q == LOOKUP && !bus.tlb_write) begin
            r_found_q <= bus.s_found;
            r_index_q <= bus.s_index;
            r_pfn_q   <= bus.s_pfn;
            r_c_q     <= bus.s_c;
            r_d_q     <= bus.s_d;
            r_v_q     <= bus.s_v;
        end
    end

endmodule

// File: tb/tb_tlb_search_arbiter.sv
// Scoreboard bench for tlb_search_arbiter with a small behavioural TLB model.
module tb_tlb_search_arbiter;
    import tlb_arb_pkg::*;

    localparam logic [7:0]  ASID     = 8'h05;
    localparam logic [18:0] PROBE_VA = 19'h3ABCD;

    typedef struct {
        owner_e      own;
        logic [18:0] vpn2;
        logic        odd;
        logic [7:0]  asid;
        logic        found;
        logic [3:0]  idx;
        logic [19:0] pfn;
        logic [2:0]  c;
        logic        d;
        logic        v;
        int          delay;
        int          due;
    } txn_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tlb_search_arbiter_if #(.TLBNUM(16)) bus ();

    tlb_search_arbiter #(.TLBNUM(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // TLB model
    logic [18:0] m_vpn2 [16];
    logic [7:0]  m_asid [16];
    logic [19:0] m_pfn0 [16];
    logic [19:0] m_pfn1 [16];
    logic        m_ok   [16];
    logic        m_hit;
    logic [3:0]  m_idx;
    logic [19:0] m_pfn;
    logic [2:0]  m_c;
    logic        m_d, m_v;

    always_comb begin
        m_hit = 1'b0; m_idx = '0; m_pfn = '0; m_c = '0; m_d = 1'b0; m_v = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (!m_hit && m_ok[i] && m_vpn2[i] == bus.s_vpn2 && m_asid[i] == bus.s_asid) begin
                m_hit = 1'b1;
                m_idx = 4'(i);
                m_pfn = bus.s_odd_page ? m_pfn1[i] : m_pfn0[i];
                m_c   = 3'(i);
                m_d   = i[0];
                m_v   = 1'b1;
            end
        end
    end

    assign bus.s_found = m_hit;
    assign bus.s_index = m_idx;
    assign bus.s_pfn   = m_pfn;
    assign bus.s_c     = m_c;
    assign bus.s_d     = m_d;
    assign bus.s_v     = m_v;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic txn_t mk(input owner_e own, input logic [18:0] vpn2, input logic odd,
                                input int delay);
        txn_t t;
        t.own = own; t.vpn2 = vpn2; t.odd = odd; t.asid = ASID;
        t.found = 1'b0; t.idx = '0; t.pfn = '0; t.c = '0; t.d = 1'b0; t.v = 1'b0;
        t.delay = delay; t.due = 0;
        for (int i = 0; i < 16; i++) begin
            if (!t.found && m_ok[i] && m_vpn2[i] == vpn2 && m_asid[i] == ASID) begin
                t.found = 1'b1; t.idx = 4'(i); t.pfn = odd ? m_pfn1[i] : m_pfn0[i];
                t.c = 3'(i); t.d = i[0]; t.v = 1'b1;
            end
        end
        return t;
    endfunction

    function automatic owner_e own_of(input logic [2:0] v);
        if (v[2]) return OWN_TLBP;
        if (v[1]) return OWN_DATA;
        return OWN_INST;
    endfunction

    txn_t exp_q[$];
    txn_t pend_q[$];
    int   gnt_cyc_q[$];
    int   cyc;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Monitor: grants pop the expectation queue, responses pop the pending queue.
    initial begin
        txn_t       t, key_exp;
        logic [2:0] g, rv;
        logic       key_chk;
        int         key_cyc;
        key_chk = 1'b0; key_cyc = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                g  = {bus.tlbp_gnt, bus.data_gnt, bus.inst_gnt};
                rv = {bus.tlbp_rvalid, bus.data_rvalid, bus.inst_rvalid};
                if (key_chk && cyc == key_cyc) begin
                    check("s_vpn2", bus.s_vpn2, key_exp.vpn2);
                    check("s_odd_page", bus.s_odd_page, key_exp.odd);
                    check("s_asid", bus.s_asid, key_exp.asid);
                    key_chk = 1'b0;
                end
                if (g != 3'b000) begin
                    check("gnt_onehot", $countones(g), 1);
                    if (exp_q.size() == 0) begin
                        check("gnt_unexpected", g, 0);
                    end else begin
                        t = exp_q.pop_front();
                        check("gnt_owner", own_of(g), t.own);
                        t.due = cyc + 2 + t.delay;
                        pend_q.push_back(t);
                        key_exp = t; key_cyc = cyc + 1; key_chk = 1'b1;
                        gnt_cyc_q.push_back(cyc);
                    end
                end
                if (rv != 3'b000) begin
                    check("rvalid_onehot", $countones(rv), 1);
                    if (pend_q.size() == 0) begin
                        check("rvalid_unexpected", rv, 0);
                    end else begin
                        t = pend_q.pop_front();
                        check("rvalid_cycle", cyc, t.due);
                        check("rvalid_owner", own_of(rv), t.own);
                        check("r_found", bus.r_found, t.found);
                        check("r_index", bus.r_index, t.idx);
                        check("r_pfn", bus.r_pfn, t.pfn);
                        check("r_c", bus.r_c, t.c);
                        check("r_d", bus.r_d, t.d);
                        check("r_v", bus.r_v, t.v);
                    end
                end
            end
        end
    end

    task automatic serve(input logic [2:0] reqs, input int budget);
        logic [2:0] pend, got;
        int         n;
        pend = reqs; n = 0;
        bus.inst_req = pend[0]; bus.data_req = pend[1]; bus.tlbp_req = pend[2];
        while (pend != 3'b000 && n < budget) begin
            @(negedge clk);
            got = {bus.tlbp_gnt, bus.data_gnt, bus.inst_gnt} & pend;
            @(posedge clk); #1;
            pend = pend & ~got;
            bus.inst_req = pend[0]; bus.data_req = pend[1]; bus.tlbp_req = pend[2];
            n++;
        end
        if (pend != 3'b000) begin
            check("serve_timeout", pend, 0);
            bus.inst_req = 1'b0; bus.data_req = 1'b0; bus.tlbp_req = 1'b0;
        end
    endtask

    // Holds one side's request until granted, then returns in the first LOOKUP cycle.
    task automatic await_gnt(input int side, input int budget);
        logic got;
        int   n;
        got = 1'b0; n = 0;
        if (side == 0) bus.inst_req = 1'b1; else bus.data_req = 1'b1;
        while (!got && n < budget) begin
            @(negedge clk);
            got = (side == 0) ? bus.inst_gnt : bus.data_gnt;
            @(posedge clk); #1;
            n++;
        end
        bus.inst_req = 1'b0; bus.data_req = 1'b0;
        if (!got) check("gnt_timeout", side, 32'hFFFF_FFFF);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || pend_q.size() != 0) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain", exp_q.size() + pend_q.size(), 0);
        exp_q.delete(); pend_q.delete();
    endtask

    initial begin
        txn_t t;
        int   t0, n;
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        txn_t t;
        int   t0, n;
        reset = 1'b1;
        bus.inst_req = 1'b0; bus.data_req = 1'b0; bus.tlbp_req = 1'b0; bus.tlb_write = 1'b0;
        bus.inst_vpn2 = '0; bus.inst_odd = 1'b0; bus.data_vpn2 = '0; bus.data_odd = 1'b0;
        bus.cp0_entryhi = {PROBE_VA, 5'd0, ASID};
        for (int i = 0; i < 16; i++) begin
            m_ok[i] = 1'b0; m_vpn2[i] = '0; m_asid[i] = '0; m_pfn0[i] = '0; m_pfn1[i] = '0;
        end
        m_ok[3] = 1'b1; m_vpn2[3] = 19'h00400;  m_asid[3] = ASID;
        m_pfn0[3] = 20'h0A000; m_pfn1[3] = 20'h1F000;
        m_ok[5] = 1'b1; m_vpn2[5] = 19'h00800;  m_asid[5] = ASID;
        m_pfn0[5] = 20'h02000; m_pfn1[5] = 20'h02001;
        m_ok[7] = 1'b1; m_vpn2[7] = PROBE_VA;   m_asid[7] = ASID;
        m_pfn0[7] = 20'h07000; m_pfn1[7] = 20'h07001;
        m_ok[9] = 1'b1; m_vpn2[9] = 19'h12345;  m_asid[9] = ASID;
        m_pfn0[9] = 20'h00111; m_pfn1[9] = 20'h00999;

        // Both refill sides requesting continuously from reset.
        bus.inst_vpn2 = 19'h00400; bus.inst_odd = 1'b1;
        bus.data_vpn2 = 19'h00800; bus.data_odd = 1'b0;
        bus.inst_req = 1'b1; bus.data_req = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_gnt", {bus.tlbp_gnt, bus.data_gnt, bus.inst_gnt}, 0);
        check("rst_rvalid", {bus.tlbp_rvalid, bus.data_rvalid, bus.inst_rvalid}, 0);
        check("rst_r_found", bus.r_found, 0);
        check("rst_r_pfn", bus.r_pfn, 0);
        check("rst_s_vpn2", bus.s_vpn2, 0);
        check("rst_s_asid", bus.s_asid, 0);
        exp_q.push_back(mk(OWN_DATA, 19'h00800, 1'b0, 0));
        exp_q.push_back(mk(OWN_INST, 19'h00400, 1'b1, 0));
        exp_q.push_back(mk(OWN_DATA, 19'h00800, 1'b0, 0));
        exp_q.push_back(mk(OWN_INST, 19'h00400, 1'b1, 0));
        gnt_cyc_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        t0 = cyc;
        n = 0;
        while (gnt_cyc_q.size() < 4 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        bus.inst_req = 1'b0; bus.data_req = 1'b0;
        check("rr_gnt_count", gnt_cyc_q.size(), 4);
        for (int k = 0; k < gnt_cyc_q.size() && k < 4; k++)
            check("rr_gnt_cycle", gnt_cyc_q[k], t0 + 3 * k);
        wait_drain(20);

        // Single instruction-side lookup, odd page of entry 3.
        bus.inst_vpn2 = 19'h00400; bus.inst_odd = 1'b1;
        exp_q.push_back(mk(OWN_INST, 19'h00400, 1'b1, 0));
        serve(3'b001, 10);
        wait_drain(20);

        // All three at once: probe first, then data (inst was served last), then inst.
        bus.data_vpn2 = 19'h00800; bus.data_odd = 1'b1;
        bus.inst_vpn2 = 19'h00400; bus.inst_odd = 1'b0;
        exp_q.push_back(mk(OWN_TLBP, PROBE_VA, 1'b0, 0));
        exp_q.push_back(mk(OWN_DATA, 19'h00800, 1'b1, 0));
        exp_q.push_back(mk(OWN_INST, 19'h00400, 1'b0, 0));
        serve(3'b111, 30);
        wait_drain(20);

        // TLB write in LOOKUP rewrites entry 9; the rerun must return the new pfn.
        bus.data_vpn2 = 19'h12345; bus.data_odd = 1'b0;
        t = mk(OWN_DATA, 19'h12345, 1'b0, 1);
        t.pfn = 20'h00222;
        exp_q.push_back(t);
        await_gnt(1, 10);
        bus.tlb_write = 1'b1;
        m_pfn0[9] = 20'h00222;
        check("lookup_busy", bus.busy, 1);
        @(posedge clk); #1;
        bus.tlb_write = 1'b0;
        wait_drain(20);

        // TLB write in IDLE blocks the grant for that cycle only.
        bus.data_vpn2 = 19'h00800; bus.data_odd = 1'b1;
        exp_q.push_back(mk(OWN_DATA, 19'h00800, 1'b1, 0));
        bus.tlb_write = 1'b1; bus.data_req = 1'b1;
        @(negedge clk);
        check("idle_write_nognt", bus.data_gnt, 0);
        @(posedge clk); #1;
        bus.tlb_write = 1'b0;
        @(negedge clk);
        check("idle_write_gnt", bus.data_gnt, 1);
        @(posedge clk); #1;
        bus.data_req = 1'b0;
        wait_drain(20);

        // Asynchronous reset during LOOKUP abandons the search.
        bus.inst_vpn2 = 19'h00400; bus.inst_odd = 1'b0;
        exp_q.push_back(mk(OWN_INST, 19'h00400, 1'b0, 0));
        await_gnt(0, 10);
        check("pre_rst_busy", bus.busy, 1);
        @(negedge clk); #1;
        reset = 1'b1;
        #1;
        check("async_rst_busy", bus.busy, 0);
        check("async_rst_r_found", bus.r_found, 0);
        check("async_rst_r_pfn", bus.r_pfn, 0);
        check("async_rst_r_index", bus.r_index, 0);
        check("async_rst_s_vpn2", bus.s_vpn2, 0);
        exp_q.delete(); pend_q.delete();
        repeat (3) begin
            @(posedge clk); #1;
            check("rst_no_rvalid", {bus.tlbp_rvalid, bus.data_rvalid, bus.inst_rvalid}, 0);
        end
        reset = 1'b0;
        // First request after reset: a TLB miss.
        bus.inst_vpn2 = 19'h55555; bus.inst_odd = 1'b0;
        exp_q.push_back(mk(OWN_INST, 19'h55555, 1'b0, 0));
        serve(3'b001, 10);
        wait_drain(20);
        repeat (4) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tlb_search_arbiter.md
# tlb_search_arbiter

Shares the TLB's single search port among three requesters: instruction-side micro-TLB refill, data-side micro-TLB refill, and the CP0 TLBP probe. It sits between the per-side micro-TLB caches and the TLB array. Each accepted request is latched and searched for one cycle. The registered result is returned to the owner with a one-cycle valid pulse. A TLB write during a search forces that search to repeat, so stale results are never returned.

## Interface
Parameters:
- TLBNUM, 16, TLB entries; index width is $clog2(TLBNUM) (4 at default).

Ports (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- inst_req  in  1  instruction-side search request; held until inst_gnt.
- inst_vpn2  in  19  VA[31:13] for the instruction request.
- inst_odd  in  1  VA[12] for the instruction request.
- inst_gnt  out  1  request accepted this cycle (combinational, IDLE only).
- inst_rvalid  out  1  one-cycle pulse: r_* holds the instruction result.
- data_req, data_vpn2, data_odd, data_gnt, data_rvalid: same as the inst_* ports, for the data side.
- tlbp_req  in  1  TLBP probe request; key is cp0_entryhi[31:13].
- tlbp_gnt  out  1  probe accepted.
- tlbp_rvalid  out  1  probe result valid.
- cp0_entryhi  in  32  [31:13] VPN2, [7:0] ASID.
- tlb_write  in  1  TLBWI/TLBWR commit this cycle.
- s_vpn2  out  19  search key to the TLB.
- s_odd_page  out  1  search key to the TLB.
- s_asid  out  8  search key to the TLB.
- s_found  in  1  TLB search result (combinational from s_*).
- s_index  in  4  TLB search result.
- s_pfn  in  20  TLB search result.
- s_c  in  3  TLB search result.
- s_d  in  1  TLB search result.
- s_v  in  1  TLB search result.
- r_found, r_index, r_pfn, r_c, r_d, r_v  out  1/4/20/3/1/1  registered result, shared by all requesters.
- busy  out  1  state != IDLE.

## Operation
- FSM states: IDLE, LOOKUP, RESP.
- IDLE:
  - If tlb_write=1, grant nothing and stay in IDLE.
  - Otherwise pick a winner. tlbp_req has the highest priority.
  - Between inst and data, round-robin on the last_served bit: when both request, the side not served last wins; with only one requesting, that side wins.
  - On a winner: assert its gnt and latch key_vpn2, key_odd, key_asid = cp0_entryhi[7:0] and owner. For TLBP, key_vpn2 = cp0_entryhi[31:13] and key_odd = 0.
  - Update last_served only for inst/data grants. Go to LOOKUP.
- LOOKUP:
  - s_* are driven from the latched key.
  - If tlb_write=0, capture s_found/s_index/s_pfn/s_c/s_d/s_v into r_* and go to RESP.
  - If tlb_write=1, do not capture and stay in LOOKUP; the search reruns next cycle.
- RESP: assert the owner's rvalid for exactly one cycle. r_* hold their values until the next capture. Return to IDLE.
- s_* always reflect the latched key, including in IDLE (no glitching on requester inputs).
- Requesters must hold key stable while req=1. A requester may drop req before gnt (cancel) with no effect. After gnt, rvalid always follows; a cancelled requester ignores it.
- Reset:
  - state=IDLE, last_served=inst, so data wins the first tie.
  - Key regs, owner and r_* are 0; all gnt/rvalid/busy are 0.
  - Reset mid-search abandons the search; no rvalid is emitted.

## Timing
- Grant: same cycle as a qualifying req in IDLE (cycle T).
- Capture: end of T+1. rvalid: cycle T+2, with r_* valid in that same cycle. Each tlb_write seen in LOOKUP adds one cycle.
- Throughput: one search per 3 cycles. A new grant is possible at T+3.
- Only one gnt and at most one rvalid are asserted in any cycle.
- tlb_write in RESP does not cancel the response; the owner's micro-TLB is responsible for invalidating on tlb_write.

## Structure
- Shared package tlb_arb_pkg holds:
  - state encodings: IDLE=2'd0, LOOKUP=2'd1, RESP=2'd2;
  - owner IDs: OWN_INST, OWN_DATA, OWN_TLBP;
  - width constants: VPN2_W=19, PFN_W=20, ASID_W=8.
- One combinational sub-module, tlb_req_pick:
  - inputs: three reqs and last_served;
  - outputs: a one-hot winner and a valid flag.
- The FSM and the key/result registers live in the top.

## Test plan
- Single inst_req, vpn2=19'h00400, odd=1, asid=8'h05, with the TLB model hitting index 3, pfn=20'h1F000 -> inst_gnt at T; s_vpn2=19'h00400 at T+1; inst_rvalid at T+2 with r_found=1, r_index=3, r_pfn=20'h1F000.
- inst_req and data_req both asserted continuously from reset -> grants alternate data, inst, data, inst at cycles 0, 3, 6, 9.
- tlbp_req, inst_req and data_req all asserted together -> tlbp_gnt first; r_index equals the probe hit index; then data, then inst.
- tlb_write pulsed during LOOKUP, with the model changing its entry from pfn 20'h00111 to 20'h00222 -> rvalid delayed one cycle and r_pfn=20'h00222.
- tlb_write in IDLE while data_req is high -> no grant that cycle; data_gnt the following cycle.
- reset asserted in LOOKUP -> busy=0 and r_*=0 immediately (asynchronous); no rvalid; a new request after reset is served normally.
